// File: rtl/mbus_tx_msg_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mbus_tx_msg_queue_pkg
// Brief    : Entry layout, entry-kind constants and FSM states shared by the
//            MBus layer-side transmit queue.
// Revision : 1.0 - initial release
// ============================================================================
package mbus_tx_msg_queue_pkg;

  // Packed so that kind lands on bit 33, flag on bit 32, payload on 31:0
  typedef struct packed {
    logic        kind;
    logic        flag;
    logic [31:0] payload;
  } entry_t;

  localparam logic KIND_HDR  = 1'b1;
  localparam logic KIND_DATA = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_REQ     = 3'd2,
    ST_ACKLOW  = 3'd3,
    ST_RESP    = 3'd4,
    ST_RESPLOW = 3'd5,
    ST_DRAIN   = 3'd6
  } state_e;

  function automatic entry_t pack_entry(input logic kind, input logic flag,
                                        input logic [31:0] payload);
    entry_t e;
    e.kind    = kind;
    e.flag    = flag;
    e.payload = payload;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mbus_txq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mbus_txq_fifo
// Brief    : Entry storage with a speculative read pointer and a commit
//            pointer; occupancy is released only on commit, rewind replays.
// Revision : 1.0 - initial release
// ============================================================================
module mbus_txq_fifo
  import mbus_tx_msg_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  input  logic   commit,
  input  logic   rewind,
  output entry_t head,
  output logic   empty,
  output logic   wr_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] cm_ptr_q, cm_ptr_d;
  logic [AW:0] used_d;
  logic        wr_ready_q, wr_ready_d;
  logic        do_push;
  entry_t      mem_q [DEPTH];

  assign do_push = push && wr_ready_q;
  assign empty   = (rd_ptr_q == wr_ptr_q);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ready = wr_ready_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d   = rewind ? cm_ptr_q : rd_ptr_q + (AW+1)'(pop && !empty);
    // Commit releases everything read so far, including this cycle's pop
    cm_ptr_d   = commit ? rd_ptr_d : cm_ptr_q;
    used_d     = wr_ptr_d - cm_ptr_d;
    wr_ready_d = (used_d < (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cm_ptr_q   <= cm_ptr_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

endmodule
`default_nettype wire

// File: rtl/mbus_tx_msg_queue.sv
`default_nettype none
// ============================================================================
// Module   : mbus_tx_msg_queue
// Brief    : Layer-side MBus transmit queue driving the wrapper's TX and
//            response four-phase handshakes. MBUS_TXQ_RETRY_EN enables
//            resending failed messages up to MAX_RETRY times.
// Revision : 1.0 - initial release
// ============================================================================
module mbus_tx_msg_queue
  import mbus_tx_msg_queue_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_RETRY  = 2
) (
  input  logic                  CLK_EXT,
  input  logic                  RESETn,
  input  logic                  WR_VALID,
  output logic                  WR_READY,
  input  logic                  WR_KIND,
  input  logic                  WR_FLAG,
  input  logic [31:0]           WR_PAYLOAD,
  output logic [ADDR_WIDTH-1:0] TX_ADDR,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_PEND,
  output logic                  TX_REQ,
  output logic                  TX_PRIORITY,
  input  logic                  TX_ACK,
  input  logic                  TX_SUCC,
  input  logic                  TX_FAIL,
  output logic                  TX_RESP_ACK,
  output logic                  MSG_DONE,
  output logic                  MSG_FAIL,
  output logic                  ORPHAN,
  output logic                  BUSY
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] tx_addr_q, tx_addr_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_pend_q, tx_pend_d;
  logic                  tx_req_q, tx_req_d;
  logic                  tx_prio_q, tx_prio_d;
  logic                  resp_ack_q, resp_ack_d;
  logic                  msg_done_q, msg_done_d;
  logic                  msg_fail_q, msg_fail_d;
  logic                  orphan_q, orphan_d;
  logic                  busy_q, busy_d;
  logic                  fail_q, fail_d;
  logic                  last_q, last_d;
  logic                  last_popped_q, last_popped_d;

  logic   fifo_pop, fifo_commit, fifo_rewind, fifo_empty, fifo_ready;
  entry_t head;

`ifdef MBUS_TXQ_RETRY_EN
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  logic [RETRY_W-1:0] retry_q, retry_d;
`else
  logic unused_retry_cfg;
  assign unused_retry_cfg = (MAX_RETRY < 0);
`endif

  mbus_txq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (CLK_EXT),
    .rst_n      (RESETn),
    .push       (WR_VALID),
    .push_entry (pack_entry(WR_KIND, WR_FLAG, WR_PAYLOAD)),
    .pop        (fifo_pop),
    .commit     (fifo_commit),
    .rewind     (fifo_rewind),
    .head       (head),
    .empty      (fifo_empty),
    .wr_ready   (fifo_ready)
  );

  always_comb begin
    state_d       = state_q;
    tx_addr_d     = tx_addr_q;
    tx_data_d     = tx_data_q;
    tx_pend_d     = tx_pend_q;
    tx_req_d      = tx_req_q;
    tx_prio_d     = tx_prio_q;
    resp_ack_d    = resp_ack_q;
    msg_done_d    = 1'b0;
    msg_fail_d    = msg_fail_q;
    orphan_d      = 1'b0;
    fail_d        = fail_q;
    last_d        = last_q;
    last_popped_d = last_popped_q;
    fifo_pop      = 1'b0;
    fifo_commit   = 1'b0;
    fifo_rewind   = 1'b0;
`ifdef MBUS_TXQ_RETRY_EN
    retry_d       = retry_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head.kind == KIND_HDR) begin
            tx_addr_d     = ADDR_WIDTH'(head.payload);
            tx_prio_d     = head.flag;
            last_popped_d = 1'b0;
            state_d       = ST_FETCH;
          end else begin
            orphan_d    = 1'b1;
            fifo_commit = 1'b1;
          end
        end
      end

      ST_FETCH: begin
        if (TX_FAIL) begin
          resp_ack_d = 1'b1;
          fail_d     = 1'b1;
          state_d    = ST_RESPLOW;
        end else if (!fifo_empty) begin
          tx_data_d = DATA_WIDTH'(head.payload);
          tx_pend_d = !head.flag;
          last_d    = head.flag;
          state_d   = ST_REQ;
        end
      end

      ST_REQ: begin
        if (TX_FAIL) begin
          tx_req_d   = 1'b0;
          resp_ack_d = 1'b1;
          fail_d     = 1'b1;
          state_d    = ST_RESPLOW;
        end else if (!tx_req_q) begin
          tx_req_d = 1'b1;
        end else if (TX_ACK) begin
          tx_req_d      = 1'b0;
          fifo_pop      = 1'b1;
          last_popped_d = last_q;
`ifndef MBUS_TXQ_RETRY_EN
          fifo_commit   = 1'b1;
`endif
          state_d       = ST_ACKLOW;
        end
      end

      ST_ACKLOW: begin
        if (TX_FAIL) begin
          resp_ack_d = 1'b1;
          fail_d     = 1'b1;
          state_d    = ST_RESPLOW;
        end else if (!TX_ACK) begin
          state_d = last_q ? ST_RESP : ST_FETCH;
        end
      end

      ST_RESP: begin
        if (TX_SUCC || TX_FAIL) begin
          resp_ack_d = 1'b1;
          fail_d     = TX_FAIL;
          state_d    = ST_RESPLOW;
        end
      end

      ST_RESPLOW: begin
        if (!TX_SUCC && !TX_FAIL) begin
          resp_ack_d = 1'b0;
`ifdef MBUS_TXQ_RETRY_EN
          if (fail_q && (retry_q < RETRY_W'(MAX_RETRY))) begin
            // Replay from the uncommitted header; no status reported yet
            fifo_rewind = 1'b1;
            retry_d     = retry_q + 1'b1;
            state_d     = ST_IDLE;
          end else begin
            msg_done_d = 1'b1;
            msg_fail_d = fail_q;
            retry_d    = '0;
            if (fail_q && !last_popped_q) begin
              state_d = ST_DRAIN;
            end else begin
              fifo_commit = 1'b1;
              state_d     = ST_IDLE;
            end
          end
`else
          msg_done_d  = 1'b1;
          msg_fail_d  = fail_q;
          fifo_commit = 1'b1;
          state_d     = (fail_q && !last_popped_q) ? ST_DRAIN : ST_IDLE;
`endif
        end
      end

      ST_DRAIN: begin
        fifo_commit = 1'b1;
        if (!fifo_empty) begin
          if (head.kind == KIND_DATA) begin
            fifo_pop = 1'b1;
            if (head.flag) state_d = ST_IDLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK_EXT or negedge RESETn) begin
    if (!RESETn) begin
      state_q       <= ST_IDLE;
      tx_addr_q     <= '0;
      tx_data_q     <= '0;
      tx_pend_q     <= 1'b0;
      tx_req_q      <= 1'b0;
      tx_prio_q     <= 1'b0;
      resp_ack_q    <= 1'b0;
      msg_done_q    <= 1'b0;
      msg_fail_q    <= 1'b0;
      orphan_q      <= 1'b0;
      busy_q        <= 1'b0;
      fail_q        <= 1'b0;
      last_q        <= 1'b0;
      last_popped_q <= 1'b0;
`ifdef MBUS_TXQ_RETRY_EN
      retry_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      tx_addr_q     <= tx_addr_d;
      tx_data_q     <= tx_data_d;
      tx_pend_q     <= tx_pend_d;
      tx_req_q      <= tx_req_d;
      tx_prio_q     <= tx_prio_d;
      resp_ack_q    <= resp_ack_d;
      msg_done_q    <= msg_done_d;
      msg_fail_q    <= msg_fail_d;
      orphan_q      <= orphan_d;
      busy_q        <= busy_d;
      fail_q        <= fail_d;
      last_q        <= last_d;
      last_popped_q <= last_popped_d;
`ifdef MBUS_TXQ_RETRY_EN
      retry_q       <= retry_d;
`endif
    end
  end

  assign WR_READY    = fifo_ready;
  assign TX_ADDR     = tx_addr_q;
  assign TX_DATA     = tx_data_q;
  assign TX_PEND     = tx_pend_q;
  assign TX_REQ      = tx_req_q;
  assign TX_PRIORITY = tx_prio_q;
  assign TX_RESP_ACK = resp_ack_q;
  assign MSG_DONE    = msg_done_q;
  assign MSG_FAIL    = msg_fail_q;
  assign ORPHAN      = orphan_q;
  assign BUSY        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mbus_tx_msg_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mbus_tx_msg_queue
// Brief    : Self-checking bench for mbus_tx_msg_queue acting as the wrapper.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mbus_tx_msg_queue;

  logic        CLK_EXT = 1'b0;
  logic        RESETn = 1'b0;
  logic        WR_VALID = 1'b0, WR_KIND = 1'b0, WR_FLAG = 1'b0;
  logic [31:0] WR_PAYLOAD = '0;
  logic        TX_ACK = 1'b0, TX_SUCC = 1'b0, TX_FAIL = 1'b0;
  logic        WR_READY, TX_PEND, TX_REQ, TX_PRIORITY, TX_RESP_ACK;
  logic        MSG_DONE, MSG_FAIL, ORPHAN, BUSY;
  logic [31:0] TX_ADDR, TX_DATA;

  int n_pass = 0, n_total = 0, orphan_cnt = 0;
  logic [31:0] words [16];

`ifdef MBUS_TXQ_RETRY_EN
  localparam int MAX_RETRY = 2;
`endif

  typedef struct { logic [31:0] addr; logic prio; int n; logic [31:0] w0; int fail_at; logic exp_fail; } vec_t;
  typedef struct { logic kind; logic flag; logic [31:0] pl; } ent_t;
  typedef struct { logic [31:0] addr; logic prio; int n; logic [3:0][31:0] w; } msg_t;

  always #5 CLK_EXT = ~CLK_EXT;

  mbus_tx_msg_queue dut (
    .CLK_EXT(CLK_EXT), .RESETn(RESETn),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_KIND(WR_KIND), .WR_FLAG(WR_FLAG),
    .WR_PAYLOAD(WR_PAYLOAD),
    .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND), .TX_REQ(TX_REQ),
    .TX_PRIORITY(TX_PRIORITY), .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL),
    .TX_RESP_ACK(TX_RESP_ACK), .MSG_DONE(MSG_DONE), .MSG_FAIL(MSG_FAIL),
    .ORPHAN(ORPHAN), .BUSY(BUSY)
  );

  always @(negedge CLK_EXT) if (RESETn && ORPHAN === 1'b1) orphan_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 400000", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return TX_REQ;
      1:       return TX_RESP_ACK;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic val, input string name);
    int n = 0;
    while (sig(sel) !== val && n < 300) begin
      @(negedge CLK_EXT);
      n++;
    end
    check(name, sig(sel), val);
  endtask

  task automatic push(input logic kind, input logic flag, input logic [31:0] pl);
    int n = 0;
    while (WR_READY !== 1'b1 && n < 300) begin
      @(negedge CLK_EXT);
      n++;
    end
    check("push_ready", WR_READY, 1'b1);
    WR_VALID = 1'b1; WR_KIND = kind; WR_FLAG = flag; WR_PAYLOAD = pl;
    @(negedge CLK_EXT);
    WR_VALID = 1'b0;
  endtask

  // Wrapper model: serves words[first..n-1]; fail_at<n fails during that word's
  // request, fail_at==n fails in the response phase, negative means success.
  task automatic run_msg(input logic [31:0] addr, input logic prio, input int n,
                         input int first, input int fail_at, input logic exp_fail);
    int attempts = 1;
`ifdef MBUS_TXQ_RETRY_EN
    if (fail_at >= 0) attempts = MAX_RETRY + 1;
`endif
    for (int a = 0; a < attempts; a++) begin
      bit aborted = 0;
      for (int w = (a == 0) ? first : 0; w < n && !aborted; w++) begin
        wait_for(0, 1'b1, "tx_req_rise");
        check("tx_addr", TX_ADDR, addr);
        check("tx_priority", TX_PRIORITY, prio);
        check("tx_data", TX_DATA, words[w]);
        check("tx_pend", TX_PEND, (w != n - 1));
        if (w == fail_at) begin
          TX_FAIL = 1'b1;
          aborted = 1;
        end else begin
          TX_ACK = 1'b1;
          wait_for(0, 1'b0, "tx_req_fall");
          TX_ACK = 1'b0;
        end
      end
      if (!aborted) begin
        if (fail_at == n) TX_FAIL = 1'b1;
        else TX_SUCC = 1'b1;
      end
      wait_for(1, 1'b1, "resp_ack_rise");
      TX_SUCC = 1'b0;
      TX_FAIL = 1'b0;
      wait_for(1, 1'b0, "resp_ack_fall");
      check("msg_done", MSG_DONE, (a == attempts - 1));
      if (a == attempts - 1) check("msg_fail", MSG_FAIL, exp_fail);
      @(negedge CLK_EXT);
    end
  endtask

  task automatic random_test(input int iters);
    int exp_orph = 0;
    int base = orphan_cnt;
    for (int it = 0; it < iters; it++) begin
      ent_t q[$];
      msg_t msgs[$];
      int nmsg = 1 + int'($urandom % 2);
      if ($urandom % 3 == 0) q.push_back('{1'b0, 1'($urandom), $urandom});
      for (int m = 0; m < nmsg; m++) begin
        int nw = 1 + int'($urandom % 2);
        q.push_back('{1'b1, 1'($urandom), $urandom});
        for (int k = 0; k < nw; k++) q.push_back('{1'b0, (k == nw - 1), $urandom});
      end
      foreach (q[i]) push(q[i].kind, q[i].flag, q[i].pl);
      // Reference parse: data where a header is expected is an orphan,
      // a header owns every following data entry up to and including last
      while (q.size() > 0) begin
        ent_t e = q.pop_front();
        if (!e.kind) exp_orph++;
        else begin
          msg_t mm;
          mm.addr = e.pl; mm.prio = e.flag; mm.n = 0; mm.w = '0;
          while (q.size() > 0) begin
            ent_t d = q.pop_front();
            mm.w[mm.n] = d.pl;
            mm.n++;
            if (d.flag) break;
          end
          msgs.push_back(mm);
        end
      end
      foreach (msgs[i]) begin
        int fa = ($urandom % 4 == 0) ? int'($urandom_range(msgs[i].n, 0)) : -1;
        for (int k = 0; k < msgs[i].n; k++) words[k] = msgs[i].w[k];
        run_msg(msgs[i].addr, msgs[i].prio, msgs[i].n, 0, fa, (fa >= 0));
      end
      repeat (4) @(negedge CLK_EXT);
      check("rand_idle", BUSY, 1'b0);
    end
    check("rand_orphans", orphan_cnt - base, exp_orph);
  endtask

  initial begin
    vec_t vecs[6];
    int o0;
    vecs[0] = '{32'h0000_0051, 1'b0, 1, 32'hDEAD_BEEF, -1, 1'b0};
    vecs[1] = '{32'h1234_5678, 1'b1, 3, 32'hA000_0000, -1, 1'b0};
    vecs[2] = '{32'hCAFE_0001, 1'b0, 3, 32'h1111_0000,  1, 1'b1};
    vecs[3] = '{32'h0000_0077, 1'b1, 2, 32'h2222_0000, -1, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 1'b0, 1, 32'h0000_0000,  0, 1'b1};
    vecs[5] = '{32'h0000_0042, 1'b0, 2, 32'h0000_0005,  2, 1'b1};

    repeat (2) @(negedge CLK_EXT);
    check("rst_wr_ready", WR_READY, 1'b0);
    check("rst_tx_req", TX_REQ, 1'b0);
    check("rst_resp_ack", TX_RESP_ACK, 1'b0);
    check("rst_msg_done", MSG_DONE, 1'b0);
    check("rst_msg_fail", MSG_FAIL, 1'b0);
    check("rst_orphan", ORPHAN, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_tx_pend", TX_PEND, 1'b0);
    RESETn = 1'b1;
    @(negedge CLK_EXT);
    check("post_rst_ready", WR_READY, 1'b1);

    foreach (vecs[i]) begin
      push(1'b1, vecs[i].prio, vecs[i].addr);
      for (int k = 0; k < vecs[i].n; k++) begin
        words[k] = vecs[i].w0 + 32'(k);
        push(1'b0, (k == vecs[i].n - 1), words[k]);
      end
      run_msg(vecs[i].addr, vecs[i].prio, vecs[i].n, 0, vecs[i].fail_at, vecs[i].exp_fail);
      repeat (4) @(negedge CLK_EXT);
      check("vec_idle", BUSY, 1'b0);
      check("vec_ready", WR_READY, 1'b1);
    end

    // Orphan data entry at the head
    o0 = orphan_cnt;
    push(1'b0, 1'b1, 32'h0BAD_0BAD);
    repeat (4) @(negedge CLK_EXT);
    check("orphan_pulses", orphan_cnt - o0, 1);
    check("orphan_idle", BUSY, 1'b0);

    // Fill to capacity, then the first acknowledged word frees space
    push(1'b1, 1'b0, 32'h0000_0300);
    for (int k = 0; k < 7; k++) begin
      words[k] = 32'h3000_0000 + 32'(k);
      push(1'b0, (k == 6), words[k]);
    end
    repeat (3) begin
      check("full_not_ready", WR_READY, 1'b0);
      @(negedge CLK_EXT);
    end
    wait_for(0, 1'b1, "fill_req_rise");
    check("fill_first_data", TX_DATA, words[0]);
    TX_ACK = 1'b1;
    wait_for(0, 1'b0, "fill_req_fall");
    TX_ACK = 1'b0;
`ifdef MBUS_TXQ_RETRY_EN
    check("ready_after_ack", WR_READY, 1'b0);
`else
    check("ready_after_ack", WR_READY, 1'b1);
`endif
    run_msg(32'h0000_0300, 1'b0, 7, 1, -1, 1'b0);
    repeat (4) @(negedge CLK_EXT);
    check("fill_ready_end", WR_READY, 1'b1);

    random_test(20);

    // Asynchronous reset while a request is outstanding
    push(1'b1, 1'b1, 32'h0000_0700);
    push(1'b0, 1'b1, 32'h7777_7777);
    wait_for(0, 1'b1, "pre_reset_req");
    #2 RESETn = 1'b0;
    #1;
    check("async_rst_req", TX_REQ, 1'b0);
    check("async_rst_resp_ack", TX_RESP_ACK, 1'b0);
    check("async_rst_busy", BUSY, 1'b0);
    @(negedge CLK_EXT);
    RESETn = 1'b1;
    @(negedge CLK_EXT);
    check("rst_release_ready", WR_READY, 1'b1);
    repeat (10) @(negedge CLK_EXT);
    check("rst_queue_empty_req", TX_REQ, 1'b0);
    check("rst_queue_empty_busy", BUSY, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
